// File: rtl/hms_timer_pkg.sv
// Shared types and constants for the HH:MM:SS timer.
// Field stepping helper wraps at both ends of a field's range.
package hms_timer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SET_SEC,
    SET_MIN,
    SET_HOUR,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  typedef enum logic [1:0] {
    FIELD_NONE = 2'd0,
    FIELD_SEC  = 2'd1,
    FIELD_MIN  = 2'd2,
    FIELD_HOUR = 2'd3
  } field_t;

  localparam logic [7:0] SEC_MAX = 8'd59;
  localparam logic [7:0] MIN_MAX = 8'd59;

  localparam int BTN_START = 0;
  localparam int BTN_MODE  = 1;
  localparam int BTN_INC   = 2;
  localparam int BTN_DEC   = 3;
  localparam int NUM_BTN   = 4;

  function automatic logic [7:0] step_field(input logic [7:0] v, input logic [7:0] vmax,
                                            input logic up);
    if (up) return (v >= vmax) ? 8'd0 : v + 8'd1;
    else    return (v == 8'd0) ? vmax : v - 8'd1;
  endfunction

endpackage

// File: rtl/hms_timer_btn_edge.sv
// Button conditioner: optional two-flop synchroniser, then rising-edge pulse.
// Pulse is visible after the 2nd (SYNC) or 1st (no SYNC) edge following the press.
module btn_edge #(
  parameter int SYNC = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic i_btn,
  output logic o_rise
);

  logic r_sync;
  logic r_prev;

  if (SYNC != 0) begin : g_sync
    logic r_meta;
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        r_meta <= 1'b0;
        r_sync <= 1'b0;
      end else begin
        r_meta <= i_btn;
        r_sync <= r_meta;
      end
    end
  end else begin : g_nosync
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_sync <= 1'b0;
      else        r_sync <= i_btn;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_prev <= 1'b0;
    else        r_prev <= r_sync;
  end

  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/hms_timer.sv
// HH:MM:SS stopwatch/countdown with setup FSM, prescaled seconds tick and blinking alarm.
// Button actions land 3 edges after press (2 without sync); outputs are registered state.
module hms_timer
  import hms_timer_pkg::*;
#(
  parameter int DIV          = 50000000,
  parameter int HOUR_MAX     = 23,
  parameter int BLINK_DIV    = 25000000,
  parameter int SYNC_BUTTONS = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        active,
  input  logic        dir,
  input  logic        btn_start,
  input  logic        btn_mode,
  input  logic        btn_inc,
  input  logic        btn_dec,
  output logic [23:0] data,
  output logic [1:0]  field,
  output logic        running,
  output logic        expired,
  output logic        wrap,
  output logic [3:0]  led
);

  if (HOUR_MAX > 255 || HOUR_MAX < 0) begin : g_hour_chk
    $error("hms_timer: HOUR_MAX must be in 0..255");
  end
  if (DIV < 2) begin : g_div_chk
    $error("hms_timer: DIV must be >= 2");
  end

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(BLINK_DIV + 1);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
  localparam logic [7:0]    HMAX       = 8'(HOUR_MAX);

  logic [NUM_BTN-1:0] w_btn, w_rise, w_ev;

  assign w_btn[BTN_START] = btn_start;
  assign w_btn[BTN_MODE]  = btn_mode;
  assign w_btn[BTN_INC]   = btn_inc;
  assign w_btn[BTN_DEC]   = btn_dec;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    btn_edge #(.SYNC(SYNC_BUTTONS)) u_edge (
      .clock  (clock),
      .reset  (reset),
      .i_btn  (w_btn[gi]),
      .o_rise (w_rise[gi])
    );
  end

  assign w_ev = w_rise & {NUM_BTN{active}};

  state_t          r_state, w_state_nxt;
  logic [7:0]      r_sec, r_min, r_hr, w_sec_nxt, w_min_nxt, w_hr_nxt;
  logic            r_dir, w_dir_nxt;
  logic [PW-1:0]   r_presc, w_presc_nxt;
  logic [BW-1:0]   r_blink, w_blink_nxt;
  logic            r_led, w_led_nxt;
  logic            r_wrap, w_wrap_nxt;

  logic            w_tick, w_zero, w_edit, w_up;
  logic            w_sec_c, w_min_c, w_full, w_sec_b, w_min_b, w_dn_zero;
  logic [7:0]      w_up_sec, w_up_min, w_up_hr, w_dn_sec, w_dn_min, w_dn_hr;

  assign w_tick = (r_state == RUN) && (r_presc == PRESC_LAST);
  assign w_zero = ({r_hr, r_min, r_sec} == 24'd0);
  assign w_edit = w_ev[BTN_INC] ^ w_ev[BTN_DEC];
  assign w_up   = w_ev[BTN_INC];

  // Carry/borrow chains for the running count
  assign w_sec_c  = (r_sec == SEC_MAX);
  assign w_min_c  = w_sec_c && (r_min == MIN_MAX);
  assign w_full   = w_min_c && (r_hr == HMAX);
  assign w_up_sec = step_field(r_sec, SEC_MAX, 1'b1);
  assign w_up_min = w_sec_c ? step_field(r_min, MIN_MAX, 1'b1) : r_min;
  assign w_up_hr  = w_min_c ? step_field(r_hr, HMAX, 1'b1) : r_hr;

  assign w_sec_b   = (r_sec == 8'd0);
  assign w_min_b   = w_sec_b && (r_min == 8'd0);
  assign w_dn_sec  = step_field(r_sec, SEC_MAX, 1'b0);
  assign w_dn_min  = w_sec_b ? step_field(r_min, MIN_MAX, 1'b0) : r_min;
  assign w_dn_hr   = w_min_b ? step_field(r_hr, HMAX, 1'b0) : r_hr;
  assign w_dn_zero = w_zero || ({w_dn_hr, w_dn_min, w_dn_sec} == 24'd0);

  always_comb begin
    w_state_nxt = r_state;
    w_sec_nxt   = r_sec;
    w_min_nxt   = r_min;
    w_hr_nxt    = r_hr;
    w_dir_nxt   = r_dir;
    w_presc_nxt = r_presc;
    w_blink_nxt = '0;
    w_led_nxt   = 1'b0;
    w_wrap_nxt  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_ev[BTN_START]) begin
          if (!(dir && w_zero)) begin
            w_state_nxt = RUN;
            w_dir_nxt   = dir;
            w_presc_nxt = '0;
          end
        end else if (w_ev[BTN_MODE]) begin
          w_state_nxt = SET_SEC;
        end
      end
      SET_SEC: begin
        if (w_edit) w_sec_nxt = step_field(r_sec, SEC_MAX, w_up);
        if (w_ev[BTN_MODE]) w_state_nxt = SET_MIN;
      end
      SET_MIN: begin
        if (w_edit) w_min_nxt = step_field(r_min, MIN_MAX, w_up);
        if (w_ev[BTN_MODE]) w_state_nxt = SET_HOUR;
      end
      SET_HOUR: begin
        if (w_edit) w_hr_nxt = step_field(r_hr, HMAX, w_up);
        if (w_ev[BTN_MODE]) w_state_nxt = IDLE;
      end
      RUN: begin
        w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
        if (w_tick && r_dir && w_dn_zero) begin
          // Expiry wins over a coincident pause press
          w_sec_nxt   = 8'd0;
          w_min_nxt   = 8'd0;
          w_hr_nxt    = 8'd0;
          w_state_nxt = EXPIRED;
          w_led_nxt   = 1'b1;
        end else begin
          if (w_tick && r_dir) begin
            w_sec_nxt = w_dn_sec;
            w_min_nxt = w_dn_min;
            w_hr_nxt  = w_dn_hr;
          end else if (w_tick) begin
            w_sec_nxt  = w_up_sec;
            w_min_nxt  = w_up_min;
            w_hr_nxt   = w_up_hr;
            w_wrap_nxt = w_full;
          end
          if (w_ev[BTN_START]) w_state_nxt = PAUSE;
        end
      end
      PAUSE: begin
        if (w_ev[BTN_START])     w_state_nxt = RUN;
        else if (w_ev[BTN_MODE]) w_state_nxt = SET_SEC;
      end
      EXPIRED: begin
        if (r_blink == BLINK_LAST) begin
          w_blink_nxt = '0;
          w_led_nxt   = ~r_led;
        end else begin
          w_blink_nxt = r_blink + 1'b1;
          w_led_nxt   = r_led;
        end
        if (w_ev[BTN_START]) begin
          w_state_nxt = IDLE;
          w_blink_nxt = '0;
          w_led_nxt   = 1'b0;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_sec   <= 8'd0;
      r_min   <= 8'd0;
      r_hr    <= 8'd0;
      r_dir   <= 1'b0;
      r_presc <= '0;
      r_blink <= '0;
      r_led   <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sec   <= w_sec_nxt;
      r_min   <= w_min_nxt;
      r_hr    <= w_hr_nxt;
      r_dir   <= w_dir_nxt;
      r_presc <= w_presc_nxt;
      r_blink <= w_blink_nxt;
      r_led   <= w_led_nxt;
      r_wrap  <= w_wrap_nxt;
    end
  end

  always_comb begin
    case (r_state)
      SET_SEC:  field = FIELD_SEC;
      SET_MIN:  field = FIELD_MIN;
      SET_HOUR: field = FIELD_HOUR;
      default:  field = FIELD_NONE;
    endcase
  end

  assign data    = {r_hr, r_min, r_sec};
  assign running = (r_state == RUN);
  assign expired = (r_state == EXPIRED);
  assign wrap    = r_wrap;
  assign led     = {4{r_led}};

endmodule

// File: tb/tb_hms_timer.sv
// Directed bench for hms_timer with DIV=4, BLINK_DIV=3, HOUR_MAX=23, synchronised buttons.
module tb_hms_timer;
  import hms_timer_pkg::*;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        active = 1'b0;
  logic        dir = 1'b0;
  logic        btn_start = 1'b0;
  logic        btn_mode = 1'b0;
  logic        btn_inc = 1'b0;
  logic        btn_dec = 1'b0;
  logic [23:0] data;
  logic [1:0]  field;
  logic        running, expired, wrap;
  logic [3:0]  led;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [3:0] B_START = 4'b0001;
  localparam logic [3:0] B_MODE  = 4'b0010;
  localparam logic [3:0] B_INC   = 4'b0100;
  localparam logic [3:0] B_DEC   = 4'b1000;

  hms_timer #(.DIV(4), .HOUR_MAX(23), .BLINK_DIV(3), .SYNC_BUTTONS(1)) dut (
    .clock     (clock),
    .reset     (reset),
    .active    (active),
    .dir       (dir),
    .btn_start (btn_start),
    .btn_mode  (btn_mode),
    .btn_inc   (btn_inc),
    .btn_dec   (btn_dec),
    .data      (data),
    .field     (field),
    .running   (running),
    .expired   (expired),
    .wrap      (wrap),
    .led       (led)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Hold the buttons for 3 edges; returns right after the action edge
  task automatic press(input logic [3:0] m);
    btn_start = m[0];
    btn_mode  = m[1];
    btn_inc   = m[2];
    btn_dec   = m[3];
    cyc(3);
    btn_start = 1'b0;
    btn_mode  = 1'b0;
    btn_inc   = 1'b0;
    btn_dec   = 1'b0;
  endtask

  task automatic tap(input logic [3:0] m);
    press(m);
    cyc(2);
  endtask

  initial begin
    #1;
    chk("rst_data", 32'(data), 32'h0);
    chk("rst_field", 32'(field), 32'h0);
    chk("rst_running", 32'(running), 32'h0);
    chk("rst_expired", 32'(expired), 32'h0);
    chk("rst_wrap", 32'(wrap), 32'h0);
    chk("rst_led", 32'(led), 32'h0);
    cyc(2);
    reset  = 1'b1;
    active = 1'b1;
    cyc(1);

    // Setup walk: sec +3, min -1, hour +2
    tap(B_MODE);
    chk("set_field_sec", 32'(field), 32'd1);
    for (int i = 0; i < 3; i++) tap(B_INC);
    chk("set_sec3", 32'(data), 32'h000003);
    tap(B_MODE);
    chk("set_field_min", 32'(field), 32'd2);
    tap(B_DEC);
    chk("set_min_dec_wrap", 32'(data), 32'h003B03);
    tap(B_MODE);
    chk("set_field_hour", 32'(field), 32'd3);
    for (int i = 0; i < 2; i++) tap(B_INC);
    tap(B_MODE);
    chk("set_field_none", 32'(field), 32'd0);
    chk("set_data", 32'(data), 32'h023B03);
    chk("set_state_idle", 32'(dut.r_state), 32'(IDLE));

    // Load 00:00:02 (min inc wraps 59 -> 0)
    tap(B_MODE);
    tap(B_DEC);
    tap(B_MODE);
    tap(B_INC);
    chk("load_min_inc_wrap", 32'(data), 32'h020002);
    tap(B_MODE);
    for (int i = 0; i < 2; i++) tap(B_DEC);
    tap(B_MODE);
    chk("load_2s", 32'(data), 32'h000002);

    // Countdown to expiry and LED blink
    dir = 1'b1;
    press(B_START);
    chk("dn_running", 32'(running), 32'd1);
    cyc(4);
    chk("dn_tick1", 32'(data), 32'h000001);
    cyc(3);
    chk("dn_pre_exp_run", 32'(running), 32'd1);
    chk("dn_pre_exp_exp", 32'(expired), 32'd0);
    cyc(1);
    chk("dn_expired", 32'(expired), 32'd1);
    chk("dn_exp_running", 32'(running), 32'd0);
    chk("dn_exp_data", 32'(data), 32'h0);
    chk("led_on_a", 32'(led), 32'hF);
    cyc(2);
    chk("led_on_b", 32'(led), 32'hF);
    cyc(1);
    chk("led_off_a", 32'(led), 32'h0);
    cyc(2);
    chk("led_off_b", 32'(led), 32'h0);
    cyc(1);
    chk("led_on_c", 32'(led), 32'hF);
    press(B_START);
    chk("ack_state", 32'(dut.r_state), 32'(IDLE));
    chk("ack_led", 32'(led), 32'h0);
    chk("ack_expired", 32'(expired), 32'd0);

    // Load 23:59:58 and count up through the wrap
    tap(B_MODE);
    tap(B_DEC);
    tap(B_DEC);
    tap(B_MODE);
    tap(B_DEC);
    tap(B_MODE);
    tap(B_DEC);
    tap(B_MODE);
    chk("load_wrap", 32'(data), 32'h173B3A);
    dir = 1'b0;
    press(B_START);
    cyc(4);
    chk("up_tick1", 32'(data), 32'h173B3B);
    chk("up_nowrap", 32'(wrap), 32'd0);
    cyc(4);
    chk("up_wrap_data", 32'(data), 32'h0);
    chk("up_wrap_pulse", 32'(wrap), 32'd1);
    cyc(1);
    chk("up_wrap_clear", 32'(wrap), 32'd0);
    cyc(3);
    chk("up_after_wrap", 32'(data), 32'h000001);
    chk("up_running", 32'(running), 32'd1);

    // Pause, reload 00:00:10 through setup
    press(B_START);
    chk("pause1_state", 32'(dut.r_state), 32'(PAUSE));
    tap(B_MODE);
    for (int i = 0; i < 9; i++) tap(B_INC);
    tap(B_MODE);
    tap(B_MODE);
    tap(B_MODE);
    chk("load_10s", 32'(data), 32'h00000A);

    // Pause with the prescaler at 2, then resume
    dir = 1'b1;
    press(B_START);
    cyc(3);
    press(B_START);
    chk("pause2_state", 32'(dut.r_state), 32'(PAUSE));
    chk("pause2_presc", 32'(dut.r_presc), 32'd2);
    chk("pause2_data", 32'(data), 32'h000009);
    cyc(20);
    chk("paused_hold", 32'(data), 32'h000009);
    chk("paused_running", 32'(running), 32'd0);
    press(B_START);
    chk("resume_running", 32'(running), 32'd1);
    chk("resume_data", 32'(data), 32'h000009);
    cyc(1);
    chk("resume_pre_tick", 32'(data), 32'h000009);
    cyc(1);
    chk("resume_tick", 32'(data), 32'h000008);

    // inc+dec together, start in SET_HOUR, start at zero counting down
    press(B_START);
    chk("pause3_state", 32'(dut.r_state), 32'(PAUSE));
    tap(B_MODE);
    for (int i = 0; i < 8; i++) tap(B_DEC);
    chk("sec_to_zero", 32'(data), 32'h0);
    tap(B_MODE);
    tap(B_INC | B_DEC);
    chk("incdec_data", 32'(data), 32'h0);
    chk("incdec_field", 32'(field), 32'd2);
    tap(B_MODE);
    tap(B_START);
    chk("start_in_set", 32'(dut.r_state), 32'(SET_HOUR));
    tap(B_MODE);
    dir = 1'b1;
    tap(B_START);
    chk("start_dn_zero", 32'(dut.r_state), 32'(IDLE));
    chk("start_dn_zero_run", 32'(running), 32'd0);

    // Load 00:05:07, run up, mask buttons, then reset mid-run
    tap(B_MODE);
    for (int i = 0; i < 7; i++) tap(B_INC);
    tap(B_MODE);
    for (int i = 0; i < 5; i++) tap(B_INC);
    tap(B_MODE);
    tap(B_MODE);
    chk("load_507", 32'(data), 32'h000507);
    dir = 1'b0;
    press(B_START);
    active = 1'b0;
    cyc(4);
    chk("inactive_count", 32'(data), 32'h000508);
    press(B_START);
    chk("inactive_no_pause", 32'(running), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst_data", 32'(data), 32'h0);
    chk("midrst_field", 32'(field), 32'h0);
    chk("midrst_running", 32'(running), 32'h0);
    chk("midrst_expired", 32'(expired), 32'h0);
    chk("midrst_wrap", 32'(wrap), 32'h0);
    chk("midrst_led", 32'(led), 32'h0);
    chk("midrst_state", 32'(dut.r_state), 32'(IDLE));
    @(negedge clock);
    reset = 1'b1;
    cyc(2);
    tap(B_START);
    tap(B_MODE);
    tap(B_INC);
    chk("masked_state", 32'(dut.r_state), 32'(IDLE));
    chk("masked_field", 32'(field), 32'h0);
    chk("masked_data", 32'(data), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
